// File: rtl/hcordic_iter_ctrl_if.sv
// Handshake bundle for the hyperbolic CORDIC iteration controller.
// Carries operand/result streams, ROM index/data and the busy flag.
interface hcordic_iter_ctrl_if #(
  parameter int DWIDTH = 32,
  parameter int IDX_W  = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [DWIDTH-1:0] in_x;
  logic [DWIDTH-1:0] in_y;
  logic [DWIDTH-1:0] in_z;
  logic [IDX_W-1:0]  shift_idx;
  logic [DWIDTH-1:0] atanh_val;
  logic              out_valid;
  logic              out_ready;
  logic [DWIDTH-1:0] out_x;
  logic [DWIDTH-1:0] out_y;
  logic [DWIDTH-1:0] out_z;
  logic              busy;

  modport slave (
    input  in_valid, in_x, in_y, in_z,
    input  atanh_val, out_ready,
    output in_ready, shift_idx,
    output out_valid, out_x, out_y, out_z,
    output busy
  );

  modport master (
    output in_valid, in_x, in_y, in_z,
    output atanh_val, out_ready,
    input  in_ready, shift_idx,
    input  out_valid, out_x, out_y, out_z,
    input  busy
  );
endinterface

// File: rtl/hcordic_iter_ctrl.sv
// Iterative hyperbolic CORDIC (rotation mode) controller, one rotation/clk.
// Ports: clk, rst_n (async low), bus = operand/result/ROM handshake bundle.
module hcordic_iter_ctrl #(
  parameter int DWIDTH    = 32,
  parameter int FRA_WIDTH = 16,
  parameter int INT_WIDTH = 15,
  parameter int N_ITER    = 16,
  parameter int IDX_W     = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  hcordic_iter_ctrl_if.slave  bus
);

  if ((N_ITER >= DWIDTH) ||
      (1 + INT_WIDTH + FRA_WIDTH != DWIDTH) ||
      ((1 << IDX_W) <= N_ITER)) begin : g_bad_cfg
    $error("hcordic_iter_ctrl: bad parameters");
  end

  localparam int RW = IDX_W + 2;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e            state_q, state_d;
  logic [DWIDTH-1:0] x_q, x_d;
  logic [DWIDTH-1:0] y_q, y_d;
  logic [DWIDTH-1:0] z_q, z_d;
  logic [DWIDTH-1:0] ox_q, ox_d;
  logic [DWIDTH-1:0] oy_q, oy_d;
  logic [DWIDTH-1:0] oz_q, oz_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [RW-1:0]     rep_q, rep_d;
  logic              rdone_q, rdone_d;
  logic              ov_q, ov_d;

  logic [DWIDTH-1:0] xs, ys;
  logic [DWIDTH-1:0] xr, yr, zr;
  logic              neg;
  logic              at_rep;
  logic              rep_now;
  logic              last;

  assign neg = z_q[DWIDTH-1];
  assign xs  = $signed(x_q) >>> idx_q;
  assign ys  = $signed(y_q) >>> idx_q;
  assign xr  = neg ? x_q - ys : x_q + ys;
  assign yr  = neg ? y_q - xs : y_q + xs;
  assign zr  = neg ? z_q + bus.atanh_val
                   : z_q - bus.atanh_val;

  // Repeat indices follow k' = 3k+1; each is run twice.
  assign at_rep  = ({2'b00, idx_q} == rep_q);
  assign rep_now = at_rep && !rdone_q;
  assign last    = (idx_q == IDX_W'(N_ITER)) && !rep_now;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    oz_d    = oz_q;
    idx_d   = idx_q;
    rep_d   = rep_q;
    rdone_d = rdone_q;
    ov_d    = ov_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          x_d     = bus.in_x;
          y_d     = bus.in_y;
          z_d     = bus.in_z;
          idx_d   = IDX_W'(1);
          rep_d   = RW'(4);
          rdone_d = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        x_d = xr;
        y_d = yr;
        z_d = zr;
        if (last) begin
          ox_d    = xr;
          oy_d    = yr;
          oz_d    = zr;
          ov_d    = 1'b1;
          idx_d   = '0;
          state_d = DONE;
        end else if (rep_now) begin
          rdone_d = 1'b1;
        end else begin
          if (at_rep) begin
            rep_d   = RW'(3) * rep_q + RW'(1);
            rdone_d = 1'b0;
          end
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          ov_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      ox_q    <= '0;
      oy_q    <= '0;
      oz_q    <= '0;
      idx_q   <= '0;
      rep_q   <= RW'(4);
      rdone_q <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      oz_q    <= oz_d;
      idx_q   <= idx_d;
      rep_q   <= rep_d;
      rdone_q <= rdone_d;
      ov_q    <= ov_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_valid = ov_q;
  assign bus.shift_idx = idx_q;
  assign bus.out_x     = ox_q;
  assign bus.out_y     = oy_q;
  assign bus.out_z     = oz_q;

endmodule

// File: doc/hcordic_iter_ctrl.md
Name: hcordic_iter_ctrl

Overview:
- Iterative controller for the hyperbolic CORDIC in rotation mode.
- Accepts one (X, Y, Z) operand set over a valid/ready handshake.
- Sequences the micro-rotations through one shared shift-add datapath, including the mandatory repeated iterations at 4, 13, 40, and so on.
- Drives the iteration index to an external atanh ROM. Holds the result until the downstream handshake completes.
- Sits between the range-reduction stages and the output formatter.

Parameters:
- DWIDTH, 32: two's-complement data width of X, Y, Z.
- FRA_WIDTH, 16: fractional bits (fixed point Q(INT_WIDTH).(FRA_WIDTH)).
- INT_WIDTH, 15: integer bits, excluding the sign.
- N_ITER, 16: last shift index. Shifts run 1..N_ITER, and N_ITER must be less than DWIDTH.
- IDX_W, 5: width of the shift index. ceil(log2(N_ITER+1)) must be at most IDX_W.

Ports:
- clk, input, 1: single clock. All state updates on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- in_valid, input, 1: operand set valid.
- in_ready, output, 1: block can accept an operand set.
- in_x, input, DWIDTH: initial X (pre-scaled by the caller).
- in_y, input, DWIDTH: initial Y.
- in_z, input, DWIDTH: initial angle Z.
- shift_idx, output, IDX_W: current shift index, addresses the external atanh ROM.
- atanh_val, input, DWIDTH: atanh(2^-shift_idx), combinational from the ROM in the same cycle.
- out_valid, output, 1: result valid.
- out_ready, input, 1: downstream accepts the result.
- out_x, output, DWIDTH: final X.
- out_y, output, DWIDTH: final Y.
- out_z, output, DWIDTH: residual Z.
- busy, output, 1: high in RUN or DONE.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State goes to IDLE.
  - in_ready=1 once in IDLE.
  - out_valid=0, busy=0, shift_idx=0.
  - out_x, out_y, out_z and the internal x, y, z registers clear to 0.
  - rep_idx=4, rep_done=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid and in_ready: latch x, y, z; set shift_idx=1, rep_idx=4, rep_done=0; go to RUN.
- RUN (in_ready=0, busy=1): one micro-rotation per clock, using the current shift_idx = i.
  - d = +1 if z[DWIDTH-1]=0, else -1.
  - x' = x + d*(y >>> i)
  - y' = y + d*(x >>> i)
  - z' = z - d*atanh_val
  - Shifts are arithmetic. Adds and subtracts wrap modulo 2^DWIDTH with no saturation. x' and y' both use the pre-update x and y.
- Schedule:
  - If i == rep_idx and rep_done=0: keep i, set rep_done=1.
  - Otherwise, if i == rep_idx (second pass): set rep_idx = 3*rep_idx+1, clear rep_done, i = i+1.
  - Otherwise: i = i+1.
  - The rotation where i == N_ITER and no repeat is pending is the last. On it, copy the updated x, y, z into out_x, out_y, out_z; set out_valid=1; set shift_idx=0; go to DONE.
- Latency:
  - Total rotations = N_ITER + number of repeat indices ≤ N_ITER.
  - For the defaults: 16 + 2 (repeats at 4 and 13) = 18.
  - out_valid rises exactly 18 clocks after the accept edge.
- DONE:
  - out_valid=1 and the outputs are held stable.
  - On out_ready=1: clear out_valid, go to IDLE. in_ready=1 from the next cycle; there is no same-cycle re-accept.
- in_valid while busy is ignored. The operand is not captured and the upstream must hold it.
- out_ready while not in DONE has no effect.
- Reset asserted mid-RUN or in DONE aborts immediately. Partial results are discarded and out_valid drops asynchronously.
- out_x, out_y, out_z change only on the transition into DONE.

Test Plan:
1. in_x=0x00013521 (1/An), in_y=0, in_z=0x00008000 (0.5), out_ready=1. Required: out_x≈0x000120AC (cosh 0.5) and out_y≈0x00008564 (sinh 0.5), each within ±16 LSB; out_z within ±16 LSB of 0; out_valid exactly 18 clocks after accept.
2. Same X and Y, in_z=0xFFFF8000 (-0.5). Required: out_x≈0x000120AC and out_y≈0xFFFF7A9C (-sinh 0.5), within ±16 LSB.
3. Shift_idx trace during any run. Required sequence: 1,2,3,4,4,5,...,12,13,13,14,15,16, then 0 in DONE.
4. Backpressure: hold out_ready=0 for 10 cycles after out_valid, pulse in_valid with new data during that time. Required: outputs stable, in_ready=0, new operand not captured; release out_ready, then in_ready=1 on the next cycle.
5. Reset mid-op: drop rst_n at rotation 7. Required: out_valid=0, in_ready=1 after release, outputs 0; the next transaction completes correctly in 18 cycles.
6. Back-to-back: two transactions with in_valid held and out_ready=1. Required: second accept no earlier than 1 cycle after the first out handshake; both results match scenario 1.
